// File: rtl/uart_bus_bridge.sv
// Byte-stream debug initiator: decodes 'W'/'R' commands from a UART receiver,
// performs one 32-bit bus access, and streams the response back to the UART transmitter.
module uart_bus_bridge #(
  parameter int BUS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_select,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        active,
  output logic        overrun
);

  // state   | meaning
  // IDLE    | waiting for a command byte
  // ADDR    | collecting A0..A3
  // WDATA   | collecting D0..D3 (write only)
  // BUS     | bus_select high, waiting for bus_ready or timeout
  // TX_SEND | tx_start pulse for the current response byte
  // TX_HOLD | one cycle for tx_busy to rise
  // TX_WAIT | waiting for the transmitter to finish the byte
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, TX_SEND, TX_HOLD, TX_WAIT} state_t;

  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state;
  logic        is_write;
  logic [1:0]  cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] resp;
  logic [2:0]  resp_len;

  assign active = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      cnt        <= 2'd0;
      tmo_cnt    <= 16'd0;
      resp       <= 32'd0;
      resp_len   <= 3'd0;
      tx_data    <= 8'd0;
      tx_start   <= 1'b0;
      bus_select <= 1'b0;
      bus_wstrb  <= 4'd0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      overrun    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      // Bytes arriving while an access or response is in flight are dropped.
      if (rx_valid && (state == BUS || state == TX_SEND || state == TX_HOLD || state == TX_WAIT))
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              is_write <= (rx_data == CMD_W);
              cnt      <= 2'd0;
              state    <= ADDR;
            end else begin
              tx_data  <= 8'h3F;
              resp_len <= 3'd1;
              tx_start <= 1'b1;
              state    <= TX_SEND;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            bus_addr[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (is_write) begin
                state <= WDATA;
              end else begin
                bus_select <= 1'b1;
                bus_wstrb  <= 4'h0;
                tmo_cnt    <= 16'd0;
                state      <= BUS;
              end
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            bus_wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              bus_select <= 1'b1;
              bus_wstrb  <= 4'hF;
              tmo_cnt    <= 16'd0;
              state      <= BUS;
            end
          end
        end
        BUS: begin
          // A ready arriving on the timeout edge still completes normally.
          if (bus_ready) begin
            bus_select <= 1'b0;
            bus_wstrb  <= 4'h0;
            tx_start   <= 1'b1;
            state      <= TX_SEND;
            if (is_write) begin
              tx_data  <= 8'h4B;
              resp_len <= 3'd1;
            end else begin
              resp     <= bus_rdata;
              tx_data  <= bus_rdata[7:0];
              resp_len <= 3'd4;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus_select <= 1'b0;
            bus_wstrb  <= 4'h0;
            tx_data    <= 8'h54;
            resp_len   <= 3'd1;
            tx_start   <= 1'b1;
            state      <= TX_SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        TX_SEND: state <= TX_HOLD;
        TX_HOLD: state <= TX_WAIT;
        TX_WAIT: begin
          if (!tx_busy) begin
            resp_len <= resp_len - 3'd1;
            resp     <= resp >> 8;
            if (resp_len > 3'd1) begin
              tx_data  <= resp[15:8];
              tx_start <= 1'b1;
              state    <= TX_SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: table of command transactions plus
// hand-written timeout, overrun and reset-mid-access sequences.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        bus_select;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        active;
  logic        overrun;

  uart_bus_bridge #(.BUS_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_select(bus_select), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .active(active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder / transmitter configuration (lat_cfg 0 = never ready)
  int          lat_cfg = 1;
  logic [31:0] rdata_cfg = 32'd0;
  int          tx_len = 3;

  int sel_cycles;
  int tcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ready  <= 1'b0;
      bus_rdata  <= 32'd0;
      sel_cycles <= 0;
    end else if (bus_select && !bus_ready) begin
      sel_cycles <= sel_cycles + 1;
      if (lat_cfg > 0 && sel_cycles + 1 == lat_cfg) begin
        bus_ready <= 1'b1;
        bus_rdata <= rdata_cfg;
      end
    end else begin
      bus_ready  <= 1'b0;
      sel_cycles <= 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tcnt    <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      tcnt    <= tx_len;
    end else if (tcnt > 1) begin
      tcnt <= tcnt - 1;
    end else begin
      tx_busy <= 1'b0;
      tcnt    <= 0;
    end
  end

  // Monitor: bus pulses, stability while selected, transmitted bytes
  int          pulses = 0;
  int          sel_high = 0;
  int          unstable = 0;
  int          tx_total = 0;
  int          tx_viol = 0;
  logic        prev_sel = 1'b0;
  logic [31:0] snap_addr = 32'd0;
  logic [31:0] snap_wdata = 32'd0;
  logic [3:0]  snap_wstrb = 4'd0;
  logic [7:0]  tx_log [256];

  always @(posedge clk) begin
    if (bus_select) begin
      sel_high <= sel_high + 1;
      if (!prev_sel) begin
        pulses     <= pulses + 1;
        snap_addr  <= bus_addr;
        snap_wdata <= bus_wdata;
        snap_wstrb <= bus_wstrb;
      end else if (bus_addr !== snap_addr || bus_wdata !== snap_wdata || bus_wstrb !== snap_wstrb) begin
        unstable <= unstable + 1;
      end
    end
    prev_sel <= bus_select;
    if (tx_start) begin
      tx_log[tx_total] <= tx_data;
      tx_total <= tx_total + 1;
      if (tx_busy) tx_viol <= tx_viol + 1;
    end
  end

  typedef struct {
    logic [8:0][7:0] cmd;
    int              ncmd;
    int              lat;
    logic [31:0]     rdata;
    int              exp_pulses;
    logic [31:0]     exp_addr;
    logic [31:0]     exp_wdata;
    logic [3:0]      exp_wstrb;
    logic [31:0]     exp_tx;
    int              ntx;
  } vec_t;

  vec_t vecs[6];
  vec_t tmo_vec;
  int   p0, t0, h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_vec(input vec_t v);
    lat_cfg   = v.lat;
    rdata_cfg = v.rdata;
    p0 = pulses;
    t0 = tx_total;
    for (int i = 0; i < v.ncmd; i++) send_byte(v.cmd[i]);
  endtask

  task automatic finish_vec(input vec_t v);
    int n;
    n = 0;
    while (active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("active_idle", 32'(active), 32'd0);
    chk("bus_pulses", 32'(pulses - p0), 32'(v.exp_pulses));
    if (v.exp_pulses > 0) begin
      chk("bus_addr", snap_addr, v.exp_addr);
      chk("bus_wstrb", 32'(snap_wstrb), 32'(v.exp_wstrb));
      if (v.exp_wstrb == 4'hF) chk("bus_wdata", snap_wdata, v.exp_wdata);
    end
    chk("tx_count", 32'(tx_total - t0), 32'(v.ntx));
    for (int j = 0; j < v.ntx; j++)
      chk("tx_byte", 32'(tx_log[t0 + j]), 32'(v.exp_tx[8*j +: 8]));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_bus_select", 32'(bus_select), 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
  endtask

  initial begin
    vecs[0] = '{cmd: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h80, 8'h00, 8'h00, 8'h10, 8'h57}, ncmd: 9,
                lat: 1, rdata: 32'h0, exp_pulses: 1, exp_addr: 32'h8000_0010,
                exp_wdata: 32'hDEAD_BEEF, exp_wstrb: 4'hF, exp_tx: 32'h0000_004B, ntx: 1};
    vecs[1] = '{cmd: {32'h0, 8'h80, 8'h00, 8'h00, 8'h0C, 8'h52}, ncmd: 5,
                lat: 3, rdata: 32'h1234_5678, exp_pulses: 1, exp_addr: 32'h8000_000C,
                exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_tx: 32'h1234_5678, ntx: 4};
    vecs[2] = '{cmd: {64'h0, 8'h41}, ncmd: 1,
                lat: 1, rdata: 32'h0, exp_pulses: 0, exp_addr: 32'h0,
                exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_tx: 32'h0000_003F, ntx: 1};
    vecs[3] = '{cmd: {32'h0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h52}, ncmd: 5,
                lat: 5, rdata: 32'hA5A5_0F0F, exp_pulses: 1, exp_addr: 32'h0000_0004,
                exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_tx: 32'hA5A5_0F0F, ntx: 4};
    vecs[4] = '{cmd: {8'h04, 8'h03, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h57}, ncmd: 9,
                lat: 2, rdata: 32'h0, exp_pulses: 1, exp_addr: 32'hFFFF_FFFF,
                exp_wdata: 32'h0403_0201, exp_wstrb: 4'hF, exp_tx: 32'h0000_004B, ntx: 1};
    vecs[5] = '{cmd: {64'h0, 8'h00}, ncmd: 1,
                lat: 1, rdata: 32'h0, exp_pulses: 0, exp_addr: 32'h0,
                exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_tx: 32'h0000_003F, ntx: 1};
    tmo_vec = '{cmd: {32'h0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h52}, ncmd: 5,
                lat: 0, rdata: 32'h0, exp_pulses: 1, exp_addr: 32'h0000_1000,
                exp_wdata: 32'h0, exp_wstrb: 4'h0, exp_tx: 32'h0000_0054, ntx: 1};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      start_vec(vecs[k]);
      finish_vec(vecs[k]);
    end
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Bus timeout: select must stay high exactly 16 cycles
    h0 = sel_high;
    start_vec(tmo_vec);
    finish_vec(tmo_vec);
    chk("timeout_sel_cycles", 32'(sel_high - h0), 32'd16);

    // Overrun: a 'W' arriving mid-response is dropped
    begin
      int n;
      tx_len = 8;
      start_vec(vecs[1]);
      n = 0;
      while (!tx_busy && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("ovr_busy_seen", 32'(tx_busy), 32'd1);
      rx_data  = 8'h57;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      finish_vec(vecs[1]);
      chk("overrun_set", 32'(overrun), 32'd1);
      repeat (4) @(negedge clk);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      chk("ovr_not_cmd", 32'(active), 32'd0);
      tx_len = 3;
    end

    // Reset mid-access drops bus_select without a clock edge
    begin
      int n;
      lat_cfg = 0;
      p0 = pulses;
      t0 = tx_total;
      for (int i = 0; i < 5; i++) send_byte(vecs[1].cmd[i]);
      n = 0;
      while (!bus_select && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("mid_sel_high", 32'(bus_select), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 chk_reset_outputs();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_no_tx", 32'(tx_total - t0), 32'd0);
      start_vec(vecs[0]);
      finish_vec(vecs[0]);
    end

    chk("tx_start_while_busy", 32'(tx_viol), 32'd0);
    chk("bus_unstable", 32'(unstable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
